cache_refill_ctrl: RTL and testbench
====================================

# cache_refill_ctrl

Miss-handling controller for the 2-way, 8-set instruction/data cache. Owns per-set valid bits and the FIFO replacement pointer, resolves hit/miss from the tag-compare datapath, and on a miss runs the memory refill: it requests a 4-word line, drives data-array writes beat by beat, writes the tag, then replays the lookup. It sits between the CPU access port, the tag/data arrays and the memory interface.

## Interface
- No parameters; geometry is fixed at 2 ways, 8 sets, 4 words/line.
- clk  in  1  single clock; all state updates on the falling edge of clk
- reset  in  1  synchronous, active-high
- cpu_req  in  1  access request; held high until cpu_ready
- cpu_index  in  3  set index of the access; stable while cpu_req high
- tag_match  in  2  raw tag-equality per way from the tag arrays (bit0 = way0), valid bits not applied
- inval  in  1  one-cycle request to clear all valid bits and FIFO pointers
- cpu_ready  out  1  one-cycle completion pulse
- cpu_way  out  1  way that serviced the access; meaningful only with cpu_ready
- cpu_miss  out  1  high with cpu_ready if the access required a refill
- busy  out  1  high in any state other than IDLE
- mem_req  out  1  line-read request to memory
- mem_ack  in  1  memory accepted the request
- mem_valid  in  1  one data beat present this cycle
- mem_index  out  3  latched index of the line being refilled
- arr_we  out  1  data-array write strobe
- arr_way  out  1  way being written
- arr_word  out  2  word offset being written
- tag_we  out  1  tag-array write strobe for (arr_way, mem_index)

## Operation
- State: valid[2][8], ptr[8] (way to evict next), latched index, victim, beat counter (2 bits), miss flag.
- FSM states: IDLE, LOOKUP, MREQ, FILL, UPDATE.
- IDLE: inval=1 → clear valid and ptr, stay IDLE (inval wins over cpu_req the same cycle). Else cpu_req=1 → latch cpu_index, clear miss flag, → LOOKUP.
- LOOKUP: hit_w = tag_match[w] & valid[w][idx]. Any hit → cpu_ready=1, cpu_way = lowest hitting way (both hitting is illegal; way0 wins), cpu_miss = miss flag, → IDLE. No hit → victim = way0 if invalid, else way1 if invalid, else ptr[idx]; set miss flag; → MREQ.
- MREQ: mem_req=1 until mem_ack sampled high; then → FILL, beat counter = 0.
- FILL: each cycle with mem_valid=1: arr_we=1, arr_way=victim, arr_word=counter, counter+1. Beat with counter=3 → UPDATE. mem_valid low inserts wait cycles.
- UPDATE (one cycle): tag_we=1, arr_way=victim; valid[victim][idx]←1; ptr[idx]←~victim; → LOOKUP (replay, which hits).
- arr_we, tag_we, mem_req, cpu_ready are combinational decodes of state and inputs; zero outside the states named.
- inval outside IDLE is ignored. mem_valid outside FILL and mem_ack outside MREQ are ignored. cpu_req deasserted mid-refill: refill completes, cpu_ready still pulses.

## Timing
- Reset: state IDLE, valid and ptr all 0, counter 0, miss flag 0; all outputs 0.
- Hit latency: cpu_req sampled at edge n → cpu_ready in the cycle after edge n.
- Miss latency: 1 (LOOKUP) + MREQ cycles (≥1) + FILL cycles (≥4) + 1 (UPDATE) + 1 (replay LOOKUP); minimum 8 cycles with mem_ack and mem_valid back-to-back.
- mem_ack in the first MREQ cycle → FILL next cycle; beats may arrive the first FILL cycle.
- Reset asserted mid-refill aborts at the next edge; no tag_we, valid unchanged by the aborted line.
- Back-to-back accesses: new cpu_req accepted in the IDLE cycle after cpu_ready.

## Configuration
- MISS_COUNT_EN defined: adds output miss_count (16 bits), incremented on each LOOKUP→MREQ transition, saturates at 16'hFFFF, cleared by reset only (not by inval).
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- After reset, req index 3, tag_match=2'b11 → miss; victim way0, 4 beats write words 0–3 to way0, tag_we once, cpu_ready with cpu_miss=1, cpu_way=0.
- Same index again, different tag → fills way1; third distinct tag → evicts way0 (ptr), fourth → evicts way1; 2'b01 match after refill → hit on way0 in 2 cycles, cpu_miss=0.
- mem_ack delayed 3 cycles, mem_valid gapped (1,0,1,1,0,1) → exactly 4 arr_we with arr_word 0,1,2,3; mem_req high until ack.
- inval and cpu_req together in IDLE → invalidation only, busy stays 0; subsequent access to a previously filled index misses.
- reset pulsed during FILL after 2 beats → IDLE next cycle, no tag_we, re-access of that index misses and fills way0.
- With MISS_COUNT_EN: 3 misses and 2 hits → miss_count=3; inval leaves it at 3.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handling for a 2-way, 8-set cache with 4-word lines.
// Tracks per-set valid bits and a FIFO eviction pointer, resolves hit/miss from
// the raw tag compare, runs the line refill from memory and replays the lookup.
// All state updates on the falling edge of clk; reset is synchronous, active-high.
// Optional feature: define MISS_COUNT_EN to add the saturating 16-bit miss_count output.
module cache_refill_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [2:0]  cpu_index,
  input  logic [1:0]  tag_match,
  input  logic        inval,
  output logic        cpu_ready,
  output logic        cpu_way,
  output logic        cpu_miss,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic        mem_valid,
  output logic [2:0]  mem_index,
  output logic        arr_we,
  output logic        arr_way,
  output logic [1:0]  arr_word,
  output logic        tag_we
`ifdef MISS_COUNT_EN
  ,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MREQ   = 3'd2,
    FILL   = 3'd3,
    UPDATE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [7:0]  valid [2];
  logic [7:0]  ptr;
  logic [2:0]  idx;
  logic        victim;
  logic [1:0]  cnt;
  logic        miss_flag;

  logic [1:0]  hit;
  logic        any_hit;
  logic        victim_sel;

  // Hit qualification and victim choice for the latched set: invalid ways first, then FIFO.
  always_comb begin
    hit        = tag_match & {valid[1][idx], valid[0][idx]};
    any_hit    = |hit;
    victim_sel = 1'b0;
    if (!valid[0][idx]) begin
      victim_sel = 1'b0;
    end else if (!valid[1][idx]) begin
      victim_sel = 1'b1;
    end else begin
      victim_sel = ptr[idx];
    end
  end

  // Next-state and strobe decode; every strobe is a pure function of state and inputs.
  always_comb begin
    state_n   = state;
    cpu_ready = 1'b0;
    cpu_way   = 1'b0;
    cpu_miss  = 1'b0;
    mem_req   = 1'b0;
    arr_we    = 1'b0;
    tag_we    = 1'b0;
    case (state)
      IDLE: begin
        if (!inval && cpu_req) begin
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        if (any_hit) begin
          cpu_ready = 1'b1;
          cpu_way   = ~hit[0];
          cpu_miss  = miss_flag;
          state_n   = IDLE;
        end else begin
          state_n = MREQ;
        end
      end
      MREQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_n = FILL;
        end
      end
      FILL: begin
        if (mem_valid) begin
          arr_we = 1'b1;
          if (cnt == 2'd3) begin
            state_n = UPDATE;
          end
        end
      end
      UPDATE: begin
        tag_we  = 1'b1;
        state_n = LOOKUP;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_index = idx;
  assign arr_way   = victim;
  assign arr_word  = cnt;

  // State register plus valid/FIFO bookkeeping, latched index, victim and beat counter.
  always_ff @(negedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid[0]  <= 8'h00;
      valid[1]  <= 8'h00;
      ptr       <= 8'h00;
      idx       <= 3'd0;
      victim    <= 1'b0;
      cnt       <= 2'd0;
      miss_flag <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (inval) begin
            valid[0] <= 8'h00;
            valid[1] <= 8'h00;
            ptr      <= 8'h00;
          end else if (cpu_req) begin
            idx       <= cpu_index;
            miss_flag <= 1'b0;
          end
        end
        LOOKUP: begin
          if (!any_hit) begin
            victim    <= victim_sel;
            miss_flag <= 1'b1;
          end
        end
        MREQ: begin
          if (mem_ack) begin
            cnt <= 2'd0;
          end
        end
        FILL: begin
          if (mem_valid) begin
            cnt <= cnt + 2'd1;
          end
        end
        UPDATE: begin
          valid[victim][idx] <= 1'b1;
          ptr[idx]           <= ~victim;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MISS_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Miss counter: bumps on every LOOKUP that falls through to MREQ; only reset clears it.
  always_ff @(negedge clk) begin
    if (reset) begin
      miss_count <= 16'd0;
    end else if (state == LOOKUP && !any_hit) begin
      miss_count <= sat_inc16(miss_count);
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: a tag-array/memory environment plus a transaction-level
// reference model (valid bits, FIFO pointer, stored tags) predicting outcome and latency.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [2:0]  cpu_index;
  logic [1:0]  tag_match;
  logic        inval;
  logic        cpu_ready;
  logic        cpu_way;
  logic        cpu_miss;
  logic        busy;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_valid;
  logic [2:0]  mem_index;
  logic        arr_we;
  logic        arr_way;
  logic [1:0]  arr_word;
  logic        tag_we;
`ifdef MISS_COUNT_EN
  logic [15:0] miss_count;
`endif

  cache_refill_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_index (cpu_index),
    .tag_match (tag_match),
    .inval     (inval),
    .cpu_ready (cpu_ready),
    .cpu_way   (cpu_way),
    .cpu_miss  (cpu_miss),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_valid (mem_valid),
    .mem_index (mem_index),
    .arr_we    (arr_we),
    .arr_way   (arr_way),
    .arr_word  (arr_word),
    .tag_we    (tag_we)
`ifdef MISS_COUNT_EN
    ,
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment: the tag arrays, written whenever the controller strobes tag_we.
  logic [3:0] etag [2][8];
  logic [3:0] cur_tag;
  assign tag_match = {etag[1][cpu_index] == cur_tag, etag[0][cpu_index] == cur_tag};
  always @(negedge clk) begin
    if (tag_we) etag[arr_way][mem_index] <= cur_tag;
  end

  // Reference model state.
  bit       mvalid [2][8];
  bit       mptr [8];
  logic [3:0] mtag [2][8];
  int       mmiss;
  bit       pat_q [$];

  task automatic model_clear(input bit full);
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) mvalid[w][s] = 1'b0;
    for (int s = 0; s < 8; s++) mptr[s] = 1'b0;
    if (full) mmiss = 0;
  endtask

  task automatic make_pat(input bit gappy);
    int ones = 0;
    pat_q.delete();
    while (ones < 4) begin
      if (gappy && $urandom_range(0, 2) == 0) pat_q.push_back(1'b0);
      else begin
        pat_q.push_back(1'b1);
        ones++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      cpu_req = 1'b0; inval = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0;
    end
  endtask

  // One CPU access: predicts outcome from the model, drives memory, checks everything seen.
  task automatic run_access(input logic [2:0] idx, input logic [3:0] t, input int d);
    bit [1:0] hitv;
    bit       exp_miss;
    bit       exp_way;
    int       exp_lat;
    int       cyc = 0, nreq = 0, nreq_obs = 0, nwe = 0, ntag = 0, pos = 0, waybad = 0;
    bit       acked = 0, done = 0, got_way = 0, got_miss = 0;
    int       rdy_cyc = -1;
    logic [7:0] words = 8'h00;
    hitv[0] = mvalid[0][idx] && (mtag[0][idx] == t);
    hitv[1] = mvalid[1][idx] && (mtag[1][idx] == t);
    exp_miss = (hitv == 2'b00);
    if (exp_miss) begin
      exp_way = !mvalid[0][idx] ? 1'b0 : (!mvalid[1][idx] ? 1'b1 : mptr[idx]);
      exp_lat = d + pat_q.size() + 4;
    end else begin
      exp_way = hitv[0] ? 1'b0 : 1'b1;
      exp_lat = 1;
    end
    while (!done && cyc < 300) begin
      @(posedge clk);
      if (cyc == 0) begin
        cpu_req = 1'b1; cpu_index = idx; cur_tag = t; inval = 1'b0;
      end
      mem_ack = 1'b0; mem_valid = 1'b0;
      if (acked && pos < pat_q.size()) begin
        mem_valid = pat_q[pos];
        pos++;
      end
      if (mem_req && !acked) begin
        if (nreq == d) mem_ack = 1'b1;
        nreq++;
      end
      #1;
      if (mem_req) nreq_obs++;
      if (arr_we) begin
        if (nwe < 4) words[2*nwe +: 2] = arr_word;
        if (arr_way !== exp_way) waybad++;
        nwe++;
      end
      if (tag_we) begin
        ntag++;
        if (arr_way !== exp_way || mem_index !== idx) waybad++;
      end
      if (cpu_ready) begin
        done = 1; rdy_cyc = cyc; got_way = cpu_way; got_miss = cpu_miss;
      end
      if (mem_ack) acked = 1;
      cyc++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL access_timeout idx=%0d tag=%0d: no cpu_ready within 300 cycles", idx, t);
    end
    n_checks++;
    if (rdy_cyc !== exp_lat) begin
      n_fail++;
      $display("FAIL latency idx=%0d tag=%0d: got %0d cycles, expected %0d", idx, t, rdy_cyc, exp_lat);
    end
    n_checks++;
    if (got_miss !== exp_miss) begin
      n_fail++;
      $display("FAIL cpu_miss idx=%0d tag=%0d: got %0b, expected %0b", idx, t, got_miss, exp_miss);
    end
    n_checks++;
    if (got_way !== exp_way) begin
      n_fail++;
      $display("FAIL cpu_way idx=%0d tag=%0d: got %0b, expected %0b", idx, t, got_way, exp_way);
    end
    n_checks++;
    if (nwe !== (exp_miss ? 4 : 0) || ntag !== (exp_miss ? 1 : 0)) begin
      n_fail++;
      $display("FAIL strobe_count idx=%0d: arr_we=%0d tag_we=%0d, expected %0d/%0d",
               idx, nwe, ntag, exp_miss ? 4 : 0, exp_miss ? 1 : 0);
    end
    n_checks++;
    if (nreq_obs !== (exp_miss ? d + 1 : 0)) begin
      n_fail++;
      $display("FAIL mem_req_cycles idx=%0d: got %0d, expected %0d", idx, nreq_obs, exp_miss ? d + 1 : 0);
    end
    n_checks++;
    if (waybad != 0) begin
      n_fail++;
      $display("FAIL write_target idx=%0d: %0d strobes with wrong way/index, expected 0", idx, waybad);
    end
    if (exp_miss) begin
      n_checks++;
      if (words !== 8'he4) begin
        n_fail++;
        $display("FAIL word_order idx=%0d: got %h, expected e4 (words 0,1,2,3)", idx, words);
      end
      mvalid[exp_way][idx] = 1'b1;
      mptr[idx] = ~exp_way;
      mtag[exp_way][idx] = t;
      mmiss++;
    end
  endtask

  task automatic do_inval(input bit with_req, input logic [2:0] idx);
    @(posedge clk);
    inval = 1'b1; cpu_req = with_req; cpu_index = idx; mem_ack = 1'b0; mem_valid = 1'b0;
    @(posedge clk);
    inval = 1'b0; cpu_req = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inval_priority: busy=%0b cpu_ready=%0b, expected 0/0", busy, cpu_ready);
    end
    model_clear(1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_req = 1'b0; cpu_index = 3'd0; inval = 1'b0;
    mem_ack = 1'b0; mem_valid = 1'b0; cur_tag = 4'd0;
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        etag[w][s] = 4'd0;
        mtag[w][s] = 4'd0;
      end
    model_clear(1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cpu_ready, cpu_way, cpu_miss, busy, mem_req, mem_index, arr_we, arr_way, arr_word, tag_we} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {cpu_ready, cpu_way, cpu_miss, busy, mem_req, mem_index, arr_we, arr_way, arr_word, tag_we});
    end
`ifdef MISS_COUNT_EN
    n_checks++;
    if (miss_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_miss_count: got %0d, expected 0", miss_count);
    end
`endif
  endtask

  task automatic test_fill_evict;
    make_pat(1'b0);
    run_access(3'd3, 4'd0, 0);
    run_access(3'd3, 4'd1, 0);
    run_access(3'd3, 4'd2, 0);
    run_access(3'd3, 4'd3, 0);
    run_access(3'd3, 4'd2, 0);
    n_checks++;
    if (mtag[0][3] !== 4'd2 || mtag[1][3] !== 4'd3 || tag_match !== 2'b01) begin
      n_fail++;
      $display("FAIL fifo_evict: way0 tag %0d way1 tag %0d match %b, expected 2/3/01",
               mtag[0][3], mtag[1][3], tag_match);
    end
    idle(1);
  endtask

  task automatic test_gapped;
    pat_q.delete();
    pat_q.push_back(1'b1); pat_q.push_back(1'b0); pat_q.push_back(1'b1);
    pat_q.push_back(1'b1); pat_q.push_back(1'b0); pat_q.push_back(1'b1);
    run_access(3'd5, 4'd7, 3);
    idle(2);
  endtask

  task automatic test_inval;
    make_pat(1'b0);
    run_access(3'd6, 4'd4, 0);
    idle(1);
    do_inval(1'b1, 3'd6);
    run_access(3'd6, 4'd4, 0);
    idle(1);
  endtask

  task automatic test_reset_mid_fill;
    int nwe = 0, ntag = 0, cyc = 0;
    @(posedge clk);
    cpu_req = 1'b1; cpu_index = 3'd2; cur_tag = 4'd9;
    while (nwe < 2 && cyc < 50) begin
      @(posedge clk);
      mem_ack = mem_req; mem_valid = (dut_fill_seen(mem_req, cyc)) ? 1'b1 : 1'b0;
      #1;
      if (arr_we) nwe++;
      if (tag_we) ntag++;
      cyc++;
    end
    @(posedge clk);
    reset = 1'b1; mem_ack = 1'b0; mem_valid = 1'b0;
    #1;
    if (tag_we) ntag++;
    @(posedge clk);
    reset = 1'b0; cpu_req = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || tag_we !== 1'b0 || ntag != 0 || nwe != 2) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%0b tag_we_seen=%0d beats=%0d, expected 0/0/2", busy, ntag, nwe);
    end
    model_clear(1'b1);
    make_pat(1'b0);
    run_access(3'd2, 4'd9, 0);
    idle(1);
  endtask

  // Beats are offered once the request has been acknowledged (mem_req no longer high).
  function automatic bit dut_fill_seen(input logic req, input int cyc);
    return (!req && cyc > 1);
  endfunction

  task automatic test_back_to_back;
    make_pat(1'b0);
    run_access(3'd1, 4'd5, 0);
    run_access(3'd1, 4'd5, 0);
    run_access(3'd4, 4'd6, 1);
    run_access(3'd1, 4'd5, 0);
    idle(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      make_pat($urandom_range(0, 1) == 1);
      run_access(3'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) do_inval($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
      else if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

`ifdef MISS_COUNT_EN
  task automatic test_miss_count;
    model_clear(1'b0);
    do_inval(1'b0, 3'd0);
    mmiss = 0;
    @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    make_pat(1'b0);
    run_access(3'd7, 4'd1, 0);
    run_access(3'd7, 4'd1, 0);
    run_access(3'd0, 4'd2, 0);
    run_access(3'd7, 4'd3, 0);
    run_access(3'd0, 4'd2, 0);
    idle(1);
    do_inval(1'b0, 3'd0);
    #1;
    n_checks++;
    if (miss_count !== 16'(mmiss) || mmiss != 3) begin
      n_fail++;
      $display("FAIL miss_count: got %0d, expected %0d", miss_count, mmiss);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_evict();
    test_gapped();
    test_inval();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
`ifdef MISS_COUNT_EN
    test_miss_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
